bf16_to_int_quant: RTL and testbench

BF16_TO_INT_QUANT -- requirements
Module: bf16_to_int_quant

---
 rtl/bf16_to_int_quant_pkg.sv | 32 +++
 rtl/bf16_to_int_quant_if.sv | 25 ++
 rtl/bf16_unpack_align.sv | 71 +++++++
 rtl/bf16_to_int_quant.sv | 150 +++++++++++++++
 tb/tb_bf16_to_int_quant.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_to_int_quant_pkg.sv
// Shared bf16 numeric definitions: field positions, bias, special exponent code
// and operand classification, used by the bf16<->int conversion blocks.
package bf16_to_int_quant_pkg;

    localparam int BF16_W        = 16;
    localparam int BF16_SIGN_BIT = 15;
    localparam int BF16_EXP_MSB  = 14;
    localparam int BF16_EXP_LSB  = 7;
    localparam int BF16_EXP_W    = 8;
    localparam int BF16_MANT_MSB = 6;
    localparam int BF16_MANT_W   = 7;
    localparam int BF16_BIAS     = 127;

    localparam logic [BF16_EXP_W-1:0] BF16_EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } bf16_class_e;

    function automatic bf16_class_e bf16_classify(input logic [BF16_EXP_W-1:0]  e,
                                                  input logic [BF16_MANT_W-1:0] m);
        if (e == '0)
            return CLS_ZERO;
        if (e == BF16_EXP_SPECIAL)
            return (m == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/bf16_to_int_quant_if.sv
// Operand-in / result-out stream bundle of the bf16 quantiser.
interface bf16_to_int_quant_if #(
    parameter int OUT_W = 8
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [15:0]             in_bf16;
    logic signed [5:0]       in_scale;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_int;
    logic                    out_sat;

    modport slave (
        input  in_valid, in_bf16, in_scale, out_ready,
        output in_ready, out_valid, out_int, out_sat
    );

    modport master (
        output in_valid, in_bf16, in_scale, out_ready,
        input  in_ready, out_valid, out_int, out_sat
    );

endinterface

// File: rtl/bf16_unpack_align.sv
// Combinational bf16 unpack: classifies the operand and aligns 1.mant to an
// INT_W-bit integer magnitude plus guard/round/sticky for a 2^scale weighting.
module bf16_unpack_align
    import bf16_to_int_quant_pkg::*;
#(
    parameter int INT_W   = 8,
    parameter int SCALE_W = 6
) (
    input  logic [BF16_W-1:0]        bf16,
    input  logic signed [SCALE_W-1:0] scale,
    output bf16_class_e              cls,
    output logic                     sign,
    output logic                     ovf,
    output logic [INT_W-1:0]         mag,
    output logic                     guard,
    output logic                     round,
    output logic                     sticky
);

    localparam int E_W  = 10;
    localparam int WW   = INT_W + 10;
    localparam int SH_W = $clog2(INT_W + 3);

    localparam logic signed [E_W-1:0] E_BIAS = E_W'(BF16_BIAS);
    localparam logic signed [E_W-1:0] E_OVF  = E_W'(INT_W);
    localparam logic signed [E_W-1:0] E_MIN  = -10'sd3;

    logic [BF16_EXP_W-1:0]  exp_f;
    logic [BF16_MANT_W-1:0] mant_f;
    logic signed [E_W-1:0]  exp_ext;
    logic signed [E_W-1:0]  scale_ext;
    logic signed [E_W-1:0]  eff_exp;
    logic [SH_W-1:0]        sh;
    logic [WW-1:0]          wide;

    assign exp_f     = bf16[BF16_EXP_MSB:BF16_EXP_LSB];
    assign mant_f    = bf16[BF16_MANT_MSB:0];
    assign exp_ext   = $signed({2'b00, exp_f});
    assign scale_ext = {{(E_W-SCALE_W){scale[SCALE_W-1]}}, scale};
    assign eff_exp   = exp_ext - E_BIAS + scale_ext;

    // wide holds value*2^10: integer in [WW-1:10], guard at 9, round at 8,
    // sticky bits below. Exponents under E_MIN only contribute sticky.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        cls    = bf16_classify(exp_f, mant_f);
        sign   = bf16[BF16_SIGN_BIT];
        ovf    = 1'b0;
        mag    = '0;
        guard  = 1'b0;
        round  = 1'b0;
        sticky = 1'b0;
        sh     = '0;
        wide   = '0;
        if (cls == CLS_NORM) begin
            if (eff_exp >= E_OVF) begin
                ovf = 1'b1;
            end else if (eff_exp < E_MIN) begin
                sticky = 1'b1;
            end else begin
                sh     = SH_W'(eff_exp - E_MIN);
                wide   = WW'({1'b1, mant_f}) << sh;
                mag    = wide[WW-1:10];
                guard  = wide[9];
                round  = wide[8];
                sticky = |wide[7:0];
            end
        end
    end

endmodule

// File: rtl/bf16_to_int_quant.sv
// Two-stage bf16 -> signed OUT_W-bit quantiser with power-of-two scale,
// round-to-nearest-even, saturation, and delivery statistics.
module bf16_to_int_quant
    import bf16_to_int_quant_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    bf16_to_int_quant_if.slave bus,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  sat_count,
    output logic              nan_seen
);

    localparam int RW = OUT_W + 1;

    localparam logic [RW-1:0] POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [RW-1:0] NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        bf16_class_e      cls;
        logic             sign;
        logic             ovf;
        logic [OUT_W-1:0] mag;
        logic             guard;
        logic             round;
        logic             sticky;
    } s1_t;

    bf16_class_e      ua_cls;
    logic             ua_sign, ua_ovf, ua_guard, ua_round, ua_sticky;
    logic [OUT_W-1:0] ua_mag;

    s1_t                     s1_q;
    logic                    s1_valid;
    logic                    s2_adv;
    logic                    in_ready_w;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_int_q;
    logic                    out_sat_q;
    logic                    out_nan_q;
    logic                    deliver;

    logic                    rnd_up;
    logic [RW-1:0]           rounded;
    logic signed [OUT_W-1:0] res_int;
    logic                    res_sat;
    logic                    res_nan;

    bf16_unpack_align #(
        .INT_W   (OUT_W),
        .SCALE_W (6)
    ) u_unpack (
        .bf16   (bus.in_bf16),
        .scale  (bus.in_scale),
        .cls    (ua_cls),
        .sign   (ua_sign),
        .ovf    (ua_ovf),
        .mag    (ua_mag),
        .guard  (ua_guard),
        .round  (ua_round),
        .sticky (ua_sticky)
    );

    // Ready chains back from the output register through S1.
    assign s2_adv        = !out_valid_q || bus.out_ready;
    assign in_ready_w    = !s1_valid || s2_adv;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_int   = out_int_q;
    assign bus.out_sat   = out_sat_q;
    assign deliver       = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready_w) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid)
                s1_q <= '{cls: ua_cls, sign: ua_sign, ovf: ua_ovf, mag: ua_mag,
                          guard: ua_guard, round: ua_round, sticky: ua_sticky};
        end
    end

    always_comb begin
        res_int = '0;
        res_sat = 1'b0;
        res_nan = 1'b0;
        rnd_up  = s1_q.guard & (s1_q.round | s1_q.sticky | s1_q.mag[0]);
        rounded = {1'b0, s1_q.mag} + RW'(rnd_up);
        unique case (s1_q.cls)
            CLS_NAN: res_nan = 1'b1;
            CLS_INF: begin
                res_sat = 1'b1;
                res_int = s1_q.sign ? INT_MIN : INT_MAX;
            end
            CLS_NORM: begin
                // A negative magnitude of exactly 2^(OUT_W-1) is representable.
                if (s1_q.ovf || (!s1_q.sign && rounded > POS_LIM)
                             || ( s1_q.sign && rounded > NEG_LIM)) begin
                    res_sat = 1'b1;
                    res_int = s1_q.sign ? INT_MIN : INT_MAX;
                end else if (s1_q.sign) begin
                    res_int = -rounded[OUT_W-1:0];
                end else begin
                    res_int = rounded[OUT_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_int_q   <= '0;
            out_sat_q   <= 1'b0;
            out_nan_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_int_q <= res_int;
                out_sat_q <= res_sat;
                out_nan_q <= res_nan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
            nan_seen  <= 1'b0;
        end else if (stat_clr) begin
            sat_count <= '0;
            nan_seen  <= 1'b0;
        end else begin
            if (deliver && out_sat_q && (sat_count != '1))
                sat_count <= sat_count + CNT_W'(1);
            if (deliver && out_nan_q)
                nan_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf16_to_int_quant.sv
// Scoreboard bench for bf16_to_int_quant: the driver queues expected results on
// each accept, an independent monitor pops and compares on each delivery.
module tb_bf16_to_int_quant;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] sat_count;
    logic        nan_seen;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int delivered = 0;
    int exp_sat_cnt = 0;

    typedef struct {
        int val;
        bit sat;
        bit lat;
        int acc;
    } exp_t;

    exp_t sb[$];

    bf16_to_int_quant_if #(.OUT_W(8)) bus ();

    bf16_to_int_quant #(.OUT_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stat_clr  (stat_clr),
        .sat_count (sat_count),
        .nan_seen  (nan_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one operand; returns one cycle after the accepting edge.
    task automatic send(input logic [15:0] v, input logic signed [5:0] sc,
                        input int exp_i, input bit exp_s, input bit lat);
        exp_t e;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.in_bf16  = v;
        bus.in_scale = sc;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                e = '{val: exp_i, sat: exp_s, lat: lat, acc: cyc + 1};
                sb.push_back(e);
                if (exp_s) exp_sat_cnt++;
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 100) begin
                check("accept_timeout", 0, 1);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: every delivered result is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                delivered++;
                if (sb.size() == 0) begin
                    check("unexpected_result", bus.out_int, 999);
                end else begin
                    e = sb.pop_front();
                    check("out_int", $signed(bus.out_int), e.val);
                    check("out_sat", bus.out_sat, e.sat);
                    if (e.lat) check("latency", cyc + 1 - e.acc, 2);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [7:0] held_int;
        int                n_valid;
        logic [15:0]       bp_vec [10];
        bp_vec = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                   16'h40C0, 16'h40E0, 16'h4100, 16'h4110, 16'h4120};

        bus.in_valid  = 1'b0;
        bus.in_bf16   = '0;
        bus.in_scale  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_int", bus.out_int, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_nan_seen", nan_seen, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Unit scale, rounding ties to even, with latency checks
        send(16'h3F80, 6'sd0,  1, 1'b0, 1'b1);
        send(16'h3FC0, 6'sd0,  2, 1'b0, 1'b1);
        send(16'h4020, 6'sd0,  2, 1'b0, 1'b1);
        send(16'hC020, 6'sd0, -2, 1'b0, 1'b1);
        drain();

        // Output range boundaries
        send(16'h4300, 6'sd0,  127, 1'b1, 1'b1);
        send(16'hC300, 6'sd0, -128, 1'b0, 1'b1);
        send(16'h42FE, 6'sd0,  127, 1'b0, 1'b0);
        send(16'hC2FF, 6'sd0, -128, 1'b0, 1'b0);
        send(16'h42FF, 6'sd0,  127, 1'b1, 1'b0);
        drain();
        check("sat_count_a", sat_count, exp_sat_cnt);

        // Scaling
        send(16'h3F00,  6'sd3,   4, 1'b0, 1'b0);
        send(16'h4280, -6'sd7,   0, 1'b0, 1'b0);
        send(16'h4040, -6'sd1,   2, 1'b0, 1'b0);
        send(16'h40A0, -6'sd2,   1, 1'b0, 1'b0);
        send(16'hBFC0,  6'sd0,  -2, 1'b0, 1'b0);
        send(16'h3FE0,  6'sd0,   2, 1'b0, 1'b0);
        send(16'h3E80,  6'sd0,   0, 1'b0, 1'b0);
        send(16'h3FC0,  6'sd31, 127, 1'b1, 1'b0);
        send(16'h3F80, -6'sd32,  0, 1'b0, 1'b0);
        drain();
        check("nan_seen_pre", nan_seen, 0);

        // Special values
        send(16'h7F80, 6'sd0,  127, 1'b1, 1'b0);
        send(16'hFF80, 6'sd0, -128, 1'b1, 1'b0);
        send(16'h7FC0, 6'sd0,    0, 1'b0, 1'b0);
        send(16'h0001, 6'sd0,    0, 1'b0, 1'b0);
        drain();
        check("nan_seen_set", nan_seen, 1);
        check("sat_count_b", sat_count, exp_sat_cnt);

        // Clear wins over a simultaneous saturated delivery
        send(16'h7F80, 6'sd0, 127, 1'b1, 1'b1);
        idle();
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        exp_sat_cnt = 0;
        check("clr_sat_count", sat_count, 0);
        check("clr_nan_seen", nan_seen, 0);
        drain();

        // Backpressure on a 10-operand back-to-back stream
        delivered = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(bp_vec[i], 6'sd0, i + 1, 1'b0, 1'b0);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", bus.in_ready, 0);
                held_int = bus.out_int;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("bp_hold_valid", bus.out_valid, 1);
                    check("bp_hold_int", bus.out_int, held_int);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", delivered, 10);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(16'h7F80, 6'sd0, 127, 1'b1, 1'b0);
        send(16'h7F80, 6'sd0, 127, 1'b1, 1'b0);
        idle();
        rst_n = 1'b0;
        sb.delete();
        exp_sat_cnt = 0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) n_valid++;
        end
        check("mid_rst_no_valid", n_valid, 0);
        check("mid_rst_sat_count", sat_count, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
